seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the on-board BCD-to-7-segment digit decoder.
- Samples a time-multiplexed, active-low 7-segment display bus (per-digit anode selects plus shared segment lines) and recovers the BCD value shown on each digit.
- Used in board loopback self-test and simulation checkers, so the display path of the MIPS system can be confirmed against the register values that drive it.
- Applies stability filtering so that scan transitions and ghosting never produce a capture.

Parameters:
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE, 4: consecutive identical samples required before a capture (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- an  in  NDIG  digit selects, active-low; bit i low selects digit i.
- seg  in  7, declared [0:6]  segment lines, active-low; index 0 = segment a through index 6 = segment g.
- err_clr  in  1  synchronous clear of the sticky err flag.
- digits  out  4*NDIG  recovered values; digit i occupies bits [4i+3:4i].
- valid  out  NDIG  bit i high = digit i last captured as a legal numeral 0-9.
- upd  out  1  one-cycle pulse on each capture.
- upd_idx  out  3  index of the digit captured, valid while upd is high.
- err  out  1  sticky: an illegal non-blank pattern was captured.

Behaviour:
- Reset (asynchronous, active-high): every output goes to 0, digits to all-ones (4'hF per digit). Internal sample registers go to an = all-ones, seg = 7'b1111111; stability counter to 0; armed to 1.
- Stage 1: an and seg are registered every clock into s_an and s_seg. This is the only path from the inputs and acts as the synchroniser.
- Stage 2: the previous sample p_an/p_seg is kept.
  - If {s_an, s_seg} differs from {p_an, p_seg}: cnt <= 0 and armed <= 1.
  - Otherwise cnt increments, saturating at STABLE-1.
- Capture fires in the cycle where all of the following hold: cnt == STABLE-1, armed == 1, and s_an has exactly one zero bit.
  - On capture, armed <= 0, so one stable period produces at most one capture.
  - If s_an is all-ones or has more than one zero, there is no capture and armed is unchanged.
- Decode on capture, pattern written as a..g (the index 0..6 order of seg):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Legal numeral: digit <= value, valid[i] <= 1.
  - Blank 1111111: digit <= 4'hF, valid[i] <= 0, err unchanged.
  - Any other pattern: digit <= 4'hE, valid[i] <= 0, err <= 1.
- digits, valid, upd, upd_idx and err are all registered and update on the capture edge. Latency: a bus value held from before edge k produces upd high in the cycle after edge k+STABLE.
- err_clr clears err on the next edge. If err_clr and an illegal capture occur in the same cycle, the set wins.
- A bus change during counting restarts the count; a partial count never captures.
- Captures of other digits leave their digit and valid bits untouched.
- Holding the same digit for a long time produces exactly one capture. Changing only seg on the same digit re-arms and allows a new capture.
- Reset mid-count discards the pending capture; the first post-reset capture needs a full STABLE window.

Test Plan:
- STABLE=4, NDIG=4. Drive an=1110, seg=0010010 for 6 cycles -> exactly one upd pulse, 5 edges after the first sample; upd_idx=0, digits[3:0]=2, valid=0001, err=0.
- Scan 1,2,3,4 on digits 0..3 at 8 cycles per digit, repeated twice -> digits=16'h4321, valid=1111, 4 upd pulses per sweep, no spurious captures at transitions.
- Hold an=1101 with seg toggling every 3 cycles -> no upd, digits unchanged; then hold 7 cycles -> single capture.
- an=1100 (two selected) or 1111, held 10 cycles -> no upd. seg=1111111 on digit 2 -> digits[11:8]=F, valid[2]=0, err=0.
- seg=1110000 on digit 1 -> digits[7:4]=E, valid[1]=0, err=1. Assert err_clr in the same cycle as a second illegal capture -> err stays 1. Assert err_clr alone -> err=0.
- Assert rst at cnt=2 -> outputs immediately zero / digits all F. After release, the same held pattern needs 5 more edges to produce upd.

Source files
------------

// File: rtl/seg_scan_capture.sv
// -----------------------------------------------------------------------------
// seg_scan_capture
//
// Receive-side decoder for a time-multiplexed, active-low 7-segment display
// bus. It watches the anode selects and the shared segment lines, waits for
// the bus to sit still for STABLE consecutive samples, and then captures the
// BCD value shown on the single selected digit. The stability filter keeps
// scan transitions and ghosting from ever producing a capture.
//
// Parameters:
//   NDIG    number of multiplexed digits (2..8)
//   STABLE  consecutive identical samples required before a capture (2..255)
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   an       digit selects, active-low (bit i low selects digit i)
//   seg      segment lines, active-low, index 0 = segment a .. 6 = segment g
//   err_clr  synchronous clear of the sticky err flag
//   digits   recovered values, digit i in bits [4i+3:4i]
//            (0-9 numeral, F blank, E illegal pattern)
//   valid    bit i high = digit i last captured as a legal numeral
//   upd      one-cycle pulse on each capture
//   upd_idx  index of the captured digit, meaningful while upd is high
//   err      sticky flag: an illegal non-blank pattern was captured
// -----------------------------------------------------------------------------
module seg_scan_capture #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NDIG-1:0]     an,
    input  logic [0:6]          seg,
    input  logic                err_clr,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic                upd,
    output logic [2:0]          upd_idx,
    output logic                err
);

    localparam logic [7:0] CntMax = 8'(STABLE - 1);

    // Stage 1: input sample (the only path from the pins).
    logic [NDIG-1:0]   s_an_q,  s_an_d;
    logic [0:6]        s_seg_q, s_seg_d;

    // Stage 2: previous sample, stability counter and re-arm flag.
    logic [NDIG-1:0]   p_an_q,  p_an_d;
    logic [0:6]        p_seg_q, p_seg_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic              armed_q, armed_d;

    // Registered outputs.
    logic [4*NDIG-1:0] digits_q,  digits_d;
    logic [NDIG-1:0]   valid_q,   valid_d;
    logic              upd_q,     upd_d;
    logic [2:0]        upd_idx_q, upd_idx_d;
    logic              err_q,     err_d;

    // Combinational helpers.
    logic              bus_same;
    logic [3:0]        zero_cnt;
    logic [2:0]        sel_idx;
    logic              one_sel;
    logic              capture;
    logic [3:0]        dec_val;
    logic              dec_legal;
    logic              dec_illegal;

    // -------------------------------------------------------------------------
    // Sample pipeline and stability counter
    // -------------------------------------------------------------------------
    always_comb begin
        s_an_d   = an;
        s_seg_d  = seg;
        p_an_d   = s_an_q;
        p_seg_d  = s_seg_q;

        bus_same = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);

        if (!bus_same) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Digit select analysis: exactly one active-low anode must be asserted
    // -------------------------------------------------------------------------
    always_comb begin
        zero_cnt = 4'd0;
        sel_idx  = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_an_q[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                sel_idx  = 3'(i);
            end
        end
        one_sel = (zero_cnt == 4'd1);
    end

    // The capture decision looks at the counter's next value so that the
    // outputs register on the same edge the window completes; a bus held
    // from before edge k therefore shows upd after edge k+STABLE.
    always_comb begin
        capture = bus_same && (cnt_d == CntMax) && armed_q && one_sel;

        armed_d = armed_q;
        if (!bus_same) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Segment pattern decode (literals written a..g, matching seg[0:6])
    // -------------------------------------------------------------------------
    always_comb begin
        dec_val     = 4'hE;
        dec_legal   = 1'b0;
        dec_illegal = 1'b0;
        case (s_seg_q)
            7'b0000001: begin dec_val = 4'd0; dec_legal = 1'b1; end
            7'b1001111: begin dec_val = 4'd1; dec_legal = 1'b1; end
            7'b0010010: begin dec_val = 4'd2; dec_legal = 1'b1; end
            7'b0000110: begin dec_val = 4'd3; dec_legal = 1'b1; end
            7'b1001100: begin dec_val = 4'd4; dec_legal = 1'b1; end
            7'b0100100: begin dec_val = 4'd5; dec_legal = 1'b1; end
            7'b0100000: begin dec_val = 4'd6; dec_legal = 1'b1; end
            7'b0001111: begin dec_val = 4'd7; dec_legal = 1'b1; end
            7'b0000000: begin dec_val = 4'd8; dec_legal = 1'b1; end
            7'b0000100: begin dec_val = 4'd9; dec_legal = 1'b1; end
            7'b1111111: begin dec_val = 4'hF; end
            default:    begin dec_val = 4'hE; dec_illegal = 1'b1; end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output next-state
    // -------------------------------------------------------------------------
    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        // Clear first so that an illegal capture in the same cycle wins.
        err_d     = err_q & ~err_clr;

        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (3'(i) == sel_idx) begin
                    digits_d[4*i +: 4] = dec_val;
                    valid_d[i]         = dec_legal;
                end
            end
            upd_d     = 1'b1;
            upd_idx_d = sel_idx;
            if (dec_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_an_q    <= '1;
            s_seg_q   <= '1;
            p_an_q    <= '1;
            p_seg_q   <= '1;
            cnt_q     <= 8'd0;
            armed_q   <= 1'b1;
            digits_q  <= '1;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            s_an_q    <= s_an_d;
            s_seg_q   <= s_seg_d;
            p_an_q    <= p_an_d;
            p_seg_q   <= p_seg_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign digits  = digits_q;
    assign valid   = valid_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned STABLE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NDIG-1:0]   an;
    logic [0:6]        seg;
    logic              err_clr;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic              upd;
    logic [2:0]        upd_idx;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int n_upd    = 0;

    seg_scan_capture #(
        .NDIG   (NDIG),
        .STABLE (STABLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .an      (an),
        .seg     (seg),
        .err_clr (err_clr),
        .digits  (digits),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Hand-written a..g patterns for the numerals.
    function automatic logic [0:6] seg_of(input int v);
        logic [0:6] p;
        case (v)
            0: p = 7'b0000001;
            1: p = 7'b1001111;
            2: p = 7'b0010010;
            3: p = 7'b0000110;
            4: p = 7'b1001100;
            5: p = 7'b0100100;
            6: p = 7'b0100000;
            7: p = 7'b0001111;
            8: p = 7'b0000000;
            9: p = 7'b0000100;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Advance one edge, sample 1 time unit later, tally upd pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (upd === 1'b1) n_upd++;
    endtask

    task automatic test_reset();
        rst = 1'b1; an = '1; seg = '1; err_clr = 1'b0;
        #1;
        n_checks++;
        if (digits !== 16'hFFFF) begin
            n_errors++; $display("FAIL reset_digits: got %h want ffff", digits);
        end
        n_checks++;
        if (valid !== 4'b0000) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0000", valid);
        end
        n_checks++;
        if ({upd, upd_idx, err} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got upd=%b idx=%0d err=%b want 0/0/0",
                                 upd, upd_idx, err);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic exp;
        n_upd = 0;
        an = 4'b1110; seg = seg_of(2);
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 5);
            n_checks++;
            if (upd !== exp) begin
                n_errors++; $display("FAIL single_upd_edge%0d: got %b want %b", e, upd, exp);
            end
            if (e == 5) begin
                n_checks++;
                if (upd_idx !== 3'd0 || digits[3:0] !== 4'd2 || valid !== 4'b0001
                    || err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_capture: got idx=%0d d0=%h valid=%b err=%b want 0/2/0001/0",
                             upd_idx, digits[3:0], valid, err);
                end
            end
        end
        an = '1; seg = '1;
        repeat (6) tick();
        n_checks++;
        if (n_upd !== 1) begin
            n_errors++; $display("FAIL single_count: got %0d pulses want 1", n_upd);
        end
    endtask

    task automatic test_scan();
        for (int sweep = 0; sweep < 2; sweep++) begin
            n_upd = 0;
            for (int d = 0; d < 4; d++) begin
                an  = ~(4'b0001 << d);
                seg = seg_of(d + 1);
                repeat (8) tick();
            end
            n_checks++;
            if (n_upd !== 4) begin
                n_errors++; $display("FAIL scan_pulses_sweep%0d: got %0d want 4", sweep, n_upd);
            end
        end
        n_checks++;
        if (digits !== 16'h4321 || valid !== 4'b1111) begin
            n_errors++; $display("FAIL scan_result: got %h/%b want 4321/1111", digits, valid);
        end
    endtask

    task automatic test_toggle();
        n_upd = 0;
        an = 4'b1101;
        for (int t = 0; t < 4; t++) begin
            seg = (t % 2 == 0) ? seg_of(1) : seg_of(7);
            repeat (3) tick();
        end
        n_checks++;
        if (n_upd !== 0 || digits !== 16'h4321) begin
            n_errors++; $display("FAIL toggle_nocap: got %0d pulses digits %h want 0/4321",
                                 n_upd, digits);
        end
        seg = seg_of(5);
        repeat (7) tick();
        n_checks++;
        if (n_upd !== 1 || digits !== 16'h4351) begin
            n_errors++; $display("FAIL toggle_hold: got %0d pulses digits %h want 1/4351",
                                 n_upd, digits);
        end
    endtask

    task automatic test_nosel_blank();
        n_upd = 0;
        an = 4'b1100; seg = seg_of(8);
        repeat (10) tick();
        an = 4'b1111;
        repeat (10) tick();
        n_checks++;
        if (n_upd !== 0 || digits !== 16'h4351) begin
            n_errors++; $display("FAIL nosel: got %0d pulses digits %h want 0/4351",
                                 n_upd, digits);
        end
        an = 4'b1011; seg = 7'b1111111;
        repeat (8) tick();
        n_checks++;
        if (n_upd !== 1 || digits !== 16'h4F51 || valid !== 4'b1011 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL blank: got n=%0d %h/%b err=%b want 1/4f51/1011/0",
                     n_upd, digits, valid, err);
        end
    endtask

    task automatic test_illegal();
        an = 4'b1101; seg = 7'b1110000;
        repeat (8) tick();
        n_checks++;
        if (digits !== 16'h4FE1 || valid !== 4'b1001 || err !== 1'b1) begin
            n_errors++; $display("FAIL illegal: got %h/%b err=%b want 4fe1/1001/1",
                                 digits, valid, err);
        end
        // Second illegal capture lands on edge 5 with err_clr high.
        an = 4'b0111; seg = 7'b1100000;
        for (int e = 1; e <= 8; e++) begin
            err_clr = (e == 5);
            tick();
        end
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b1 || digits !== 16'hEFE1 || valid !== 4'b0001) begin
            n_errors++; $display("FAIL set_wins: got err=%b %h/%b want 1/efe1/0001",
                                 err, digits, valid);
        end
        an = '1; seg = '1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL err_clear: got %b want 0", err);
        end
    endtask

    task automatic test_rst_mid();
        logic exp;
        n_upd = 0;
        an = 4'b1110; seg = seg_of(9);
        repeat (4) tick();
        n_checks++;
        if (n_upd !== 0) begin
            n_errors++; $display("FAIL rst_precount: got %0d pulses want 0", n_upd);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (digits !== 16'hFFFF || valid !== 4'b0000 || upd !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL rst_async: got %h/%b upd=%b err=%b want ffff/0000/0/0",
                                 digits, valid, upd, err);
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 5);
            n_checks++;
            if (upd !== exp) begin
                n_errors++; $display("FAIL rst_upd_edge%0d: got %b want %b", e, upd, exp);
            end
        end
        n_checks++;
        if (digits !== 16'hFFF9 || valid !== 4'b0001) begin
            n_errors++; $display("FAIL rst_recapture: got %h/%b want fff9/0001", digits, valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_toggle();
        test_nosel_blank();
        test_illegal();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
